// File: rtl/counter_bank_core.sv
`default_nettype none
// ============================================================================
// Module   : counter_bank_core
// Purpose  : Bank of NUM_CHANNELS independent event counters driven by
//            asynchronous pad-level enables. Each counter supports
//            up/down counting, wrap or saturate, level or edge counting,
//            parallel load and a sticky overflow flag. An atomic snapshot of
//            all counters is read out one OUT_WIDTH segment at a time.
// Ports    : clk_i        core clock
//            rst_ni       asynchronous active-low reset
//            chan_en_i    per-channel count request (asynchronous pad level)
//            edge_mode_i  0: count every enabled cycle, 1: rising edges only
//            mode_i       00 up-wrap, 01 down-wrap, 10 up-sat, 11 down-sat
//            clear_i      synchronous clear of all counters and ovf flags
//            load_i       load load_val_i into channel sel_i
//            load_val_i   load value
//            snapshot_i   copy all counters into the shadow registers
//            sel_i        channel for load and readout
//            seg_i        readout segment, 0 = least significant
//            out_data_o   registered segment of shadow[sel_i]
//            ovf_o        sticky overflow/limit flags
// Revision : 1.0 - initial release
// ============================================================================
module counter_bank_core #(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int OUT_WIDTH    = 8,
    parameter int SEL_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int SEG_W        = ((CNT_WIDTH / OUT_WIDTH) > 1) ?
                                 $clog2(CNT_WIDTH / OUT_WIDTH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CHANNELS-1:0] chan_en_i,
    input  logic                    edge_mode_i,
    input  logic [1:0]              mode_i,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [CNT_WIDTH-1:0]    load_val_i,
    input  logic                    snapshot_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [SEG_W-1:0]        seg_i,
    output logic [OUT_WIDTH-1:0]    out_data_o,
    output logic [NUM_CHANNELS-1:0] ovf_o
);

    localparam int                   NUM_SEGS = CNT_WIDTH / OUT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [NUM_CHANNELS-1:0] sync1_q;
    logic [NUM_CHANNELS-1:0] sync2_q;
    logic [NUM_CHANNELS-1:0] sync3_q;
    logic [NUM_CHANNELS-1:0] strobe;

    logic [CNT_WIDTH-1:0]    cnt_q    [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]    cnt_d    [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]    shadow_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ovf_q;
    logic [NUM_CHANNELS-1:0] ovf_d;
    logic [OUT_WIDTH-1:0]    out_data_q;
    logic [OUT_WIDTH-1:0]    out_data_d;

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= chan_en_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign strobe = edge_mode_i ? (sync2_q & ~sync3_q) : sync2_q;

    // Per-channel next state: clear > load > count > hold. A sel_i value with
    // no matching channel never matches, so such loads are dropped.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clear_i) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (load_i && (sel_i == SEL_W'(i))) begin
                cnt_d[i] = load_val_i;
            end else if (strobe[i]) begin
                if (!mode_i[0]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        ovf_d[i] = 1'b1;
                        cnt_d[i] = mode_i[1] ? CNT_MAX : '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                    end
                end else begin
                    if (cnt_q[i] == '0) begin
                        ovf_d[i] = 1'b1;
                        cnt_d[i] = mode_i[1] ? '0 : CNT_MAX;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Readout mux; out-of-range channel or segment selects fall through to 0.
    always_comb begin
        out_data_d = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            for (int k = 0; k < NUM_SEGS; k++) begin
                if ((sel_i == SEL_W'(i)) && (seg_i == SEG_W'(k))) begin
                    out_data_d = shadow_q[i][k*OUT_WIDTH +: OUT_WIDTH];
                end
            end
        end
    end

    // Shadow samples the pre-update counters and ignores clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            ovf_q      <= '0;
            out_data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (snapshot_i) begin
                    shadow_q[i] <= cnt_q[i];
                end
            end
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data_o = out_data_q;
    assign ovf_o      = ovf_q;

endmodule
`default_nettype wire
